// File: rtl/uart_rx_fifo_pkg.sv
// Shared constants for the UART receive byte buffer.
package uart_rx_fifo_pkg;
    localparam int BYTE_W    = 8;
    localparam int DEF_AW    = 4;
    localparam int DEF_AFULL = 12;
endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x W register array: synchronous write port, asynchronous read port.
module uart_fifo_mem #(
    parameter int AW = 4,
    parameter int W  = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/uart_rx_fifo.sv
// Byte FIFO between the UART receiver and core logic; absorbs consumer stalls
// so the receiver never waits in its hand-off state.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int AW    = DEF_AW,
    parameter int AFULL = DEF_AFULL
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [BYTE_W-1:0] in__data,
    input  logic              in__valid,
    output logic              in__ready,
    output logic [BYTE_W-1:0] out__data,
    output logic              out__valid,
    input  logic              out__ready,
    output logic [AW:0]       level,
    output logic              almost_full
);
    localparam logic [AW:0] DEPTH_V = (AW+1)'(2**AW);
    localparam logic [AW:0] AFULL_V = (AW+1)'(AFULL);

    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic          push;
    logic          pop;

    // All handshake outputs decode registered state only; no path from out__ready.
    assign in__ready   = (count != DEPTH_V);
    assign out__valid  = (count != '0);
    assign level       = count;
    assign almost_full = (count >= AFULL_V);

    assign push = in__valid && in__ready;
    assign pop  = out__valid && out__ready;

    uart_fifo_mem #(
        .AW (AW),
        .W  (BYTE_W)
    ) u_mem (
        .clk   (clk),
        .we    (push && !flush && !rst),
        .waddr (wr_ptr),
        .wdata (in__data),
        .raddr (rd_ptr),
        .rdata (out__data)
    );

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo against a queue-based reference model.
module tb_uart_rx_fifo;
    localparam int DEPTH = 16;
    localparam int AFULL = 12;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic [7:0] in__data;
    logic       in__valid;
    logic       in__ready;
    logic [7:0] out__data;
    logic       out__valid;
    logic       out__ready;
    logic [4:0] level;
    logic       almost_full;

    int vectors    = 0;
    int miscompares = 0;
    logic [7:0] q[$];

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .AW    (4),
        .AFULL (AFULL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in__data    (in__data),
        .in__valid   (in__valid),
        .in__ready   (in__ready),
        .out__data   (out__data),
        .out__valid  (out__valid),
        .out__ready  (out__ready),
        .level       (level),
        .almost_full (almost_full)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        int n;
        n = q.size();
        chk({tag, ".out_valid"}, 16'(out__valid), 16'(n != 0));
        chk({tag, ".in_ready"}, 16'(in__ready), 16'(n != DEPTH));
        chk({tag, ".level"}, 16'(level), 16'(n));
        chk({tag, ".almost_full"}, 16'(almost_full), 16'(n >= AFULL));
        if (n != 0) begin
            chk({tag, ".out_data"}, 16'(out__data), 16'(q[0]));
        end
    endtask

    // Drive one cycle at the negedge, update the model, check at the next negedge.
    task automatic cycle(input string tag, input logic v, input logic [7:0] d,
                         input logic r, input logic f);
        bit do_push;
        bit do_pop;
        in__valid  = v;
        in__data   = d;
        out__ready = r;
        flush      = f;
        do_push = v && (q.size() < DEPTH);
        do_pop  = r && (q.size() > 0);
        if (f) begin
            q.delete();
        end else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(d);
        end
        @(posedge clk);
        @(negedge clk);
        in__valid = 1'b0;
        out__ready = 1'b0;
        flush = 1'b0;
        check_outputs(tag);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        q.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_outputs("reset");
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        in__valid = 1'b0;
        in__data = '0;
        out__ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        do_reset();
        cycle("idle", 1'b0, 8'h00, 1'b0, 1'b0);
        chk("idle.level_const", 16'(level), 16'd0);

        cycle("push55", 1'b1, 8'h55, 1'b0, 1'b0);
        chk("push55.data_const", 16'(out__data), 16'h55);
        chk("push55.level_const", 16'(level), 16'd1);
        cycle("hold55", 1'b0, 8'h00, 1'b0, 1'b0);
        cycle("pop55", 1'b0, 8'h00, 1'b1, 1'b0);
        chk("pop55.valid_const", 16'(out__valid), 16'd0);

        for (int i = 0; i < DEPTH; i++) begin
            cycle("fill", 1'b1, 8'(i), 1'b0, 1'b0);
        end
        chk("fill.ready_const", 16'(in__ready), 16'd0);
        cycle("push17", 1'b1, 8'hAA, 1'b0, 1'b0);
        chk("push17.level_const", 16'(level), 16'd16);
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain.order", 16'(out__data), 16'(i));
            cycle("drain", 1'b0, 8'h00, 1'b1, 1'b0);
        end

        for (int i = 0; i < DEPTH; i++) begin
            cycle("refill", 1'b1, 8'(i), 1'b0, 1'b0);
        end
        cycle("full_pp", 1'b1, 8'hB0, 1'b1, 1'b0);
        chk("full_pp.level_const", 16'(level), 16'd15);
        cycle("full_pp2", 1'b1, 8'hB0, 1'b0, 1'b0);
        chk("full_pp2.level_const", 16'(level), 16'd16);

        cycle("flush_a", 1'b0, 8'h00, 1'b0, 1'b1);
        cycle("lvl1", 1'b1, 8'h80, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            chk("stream.delay1", 16'(out__data), 16'(8'h80 + 8'(i)));
            cycle("stream", 1'b1, 8'h81 + 8'(i), 1'b1, 1'b0);
            chk("stream.level_const", 16'(level), 16'd1);
        end

        cycle("flush_b", 1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cycle("lvl5", 1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
        end
        cycle("flush77", 1'b1, 8'h77, 1'b0, 1'b1);
        chk("flush77.level_const", 16'(level), 16'd0);
        cycle("after77", 1'b1, 8'h01, 1'b0, 1'b0);
        chk("after77.data_const", 16'(out__data), 16'h01);

        for (int i = 0; i < 400; i++) begin
            cycle("rand", 1'($urandom_range(0, 3) != 0), 8'($urandom),
                  1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 49) == 0));
            if (i == 200) begin
                do_reset();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
